lcd_4bit_ctrl: RTL and testbench
================================

// Module: lcd_4bit_ctrl
// PURPOSE
//  Parametrised HD44780-style 4-bit LCD controller.
//  - Runs the full power-on init sequence, then the configuration sequence.
//  - Accepts command/data bytes from a client over a valid/ready handshake.
//  - Sends each byte as two nibbles, upper first, with timed E pulses.
//  - Waits the controller execution time after every byte.
//  - Sits between the display-formatting logic and the LCD pins; shares the bus with StrataFlash.
// PARAMETERS
//  T_POWERON   750000  cycles to wait after reset before the first nibble (15 ms @ 50 MHz)
//  T_INIT1     205000  wait after 1st 0x3 init nibble (4.1 ms)
//  T_INIT2     5000    wait after 2nd 0x3 init nibble (100 us)
//  T_EXEC      2000    wait after 3rd 0x3, after 0x2, and after any normal byte (40 us)
//  T_CLEAR     82000   wait after command bytes 0x01/0x02/0x03 (1.64 ms)
//  T_SETUP     2       cycles data/RS are stable before E rises
//  T_PULSE     12      cycles E stays high per nibble
//  T_GAP       50      cycles between the upper-nibble E fall and the lower-nibble setup (1 us)
//  CNT_W       32      width of the shared delay counter
// PORTS
//  Clock                    in   1  system clock
//  Reset_n                  in   1  asynchronous, active-low reset
//  iValid                   in   1  client presents a byte
//  iRS                      in   1  byte type: 0=command, 1=data
//  iByte                    in   8  byte to write
//  oReady                   out  1  controller idle; can accept a byte
//  oInitDone                out  1  init + configuration complete (sticky until reset)
//  oLCD_Enabled             out  1  LCD E strobe
//  oLCD_RegisterSelect      out  1  LCD RS
//  oLCD_ReadWrite           out  1  constant 0 (write only)
//  oLCD_StrataFlashControl  out  1  constant 1 (StrataFlash disabled)
//  oLCD_Data                out  4  LCD DB7..DB4
// BEHAVIOUR
//  - Reset (async, Reset_n=0):
//    - All registered outputs clear immediately: E=0, RS=0, Data=0, oReady=0, oInitDone=0.
//    - Delay counter clears; FSM enters PWR_WAIT.
//    - Reset asserted mid-pulse drops E in the same instant.
//  - Nibble write (NIB sub-sequence, used everywhere):
//    - Drive Data/RS for T_SETUP cycles with E=0.
//    - Then hold E=1 for exactly T_PULSE cycles.
//    - Data/RS do not change until at least 1 cycle after E falls.
//  - Init sequence, all with RS=0:
//    - PWR_WAIT: wait T_POWERON cycles.
//    - NIB 0x3, wait T_INIT1.
//    - NIB 0x3, wait T_INIT2.
//    - NIB 0x3, wait T_EXEC.
//    - NIB 0x2, wait T_EXEC.
//  - Configuration sequence:
//    - Byte writes, RS=0: 0x28, 0x06, 0x0C, 0x01 (the last is followed by T_CLEAR).
//    - Then IDLE; oInitDone=1 and oReady=1 on the first IDLE cycle.
//  - Byte write sequence:
//    - SETUP_HI / PULSE_HI send iByte[7:4].
//    - GAP: T_GAP cycles.
//    - SETUP_LO / PULSE_LO send iByte[3:0].
//    - EXEC_WAIT: T_CLEAR if RS=0 and byte is 0x01..0x03, else T_EXEC. Then return to IDLE.
//  - Handshake:
//    - A byte is accepted on the rising edge where iValid && oReady.
//    - iRS/iByte are captured on that edge; oReady=0 from the next cycle.
//    - iValid while oReady=0 is ignored: no queuing, no error.
//    - oReady is never 1 before oInitDone.
//  - Latency: E first rises T_SETUP cycles after acceptance.
//  - Byte-to-next-oReady time: 2*(T_SETUP+T_PULSE)+T_GAP+wait+1 cycles.
//  - Delay counter:
//    - Cleared on every state entry.
//    - A wait of N means the state exits after exactly N cycles.
//    - The counter never wraps within a wait; CNT_W must hold the largest T_*.
//  - In IDLE, E=0 and Data/RS hold their last values.
//  - oLCD_ReadWrite and oLCD_StrataFlashControl are constant at all times, including during reset.
// TESTING (bench params: T_POWERON=20 T_INIT1=10 T_INIT2=5 T_EXEC=4 T_CLEAR=15 T_SETUP=2 T_PULSE=3 T_GAP=2)
//  - Reset release -> 20 idle cycles, then E pulses with Data 3,3,3,2 (RS=0) at gaps 10/5/4.
//    Then nibble pairs 2/8, 0/6, 0/C, 0/1. oReady=1 15 cycles after the last pulse.
//  - iValid=1 iRS=1 iByte=0x41 in IDLE -> RS=1, Data 4 for 3 cycles E-high, gap 2, Data 1 for 3 cycles E-high.
//    oReady returns 4 cycles later; every E-high run is exactly 3 cycles.
//  - iRS=0 iByte=0x01 -> post-byte wait is 15 cycles. Then iByte=0x80 -> wait is 4 cycles.
//  - iValid held high through a busy byte with a changing iByte -> only the byte present at acceptance is sent.
//    The next accept occurs on the first oReady cycle.
//  - Reset_n pulsed low during PULSE_LO -> E=0, oReady=0, oInitDone=0 asynchronously.
//    The full init sequence repeats after release.
//  - iValid=1 throughout init -> nothing is accepted before oInitDone=1.
//    Checker: Data/RS stable whenever E=1; RW=0 and SF=1 in every cycle.

Source files
------------

// File: rtl/lcd_4bit_ctrl.sv
// HD44780-style 4-bit LCD write controller: power-on init, configuration bytes,
// then client bytes sent as two timed nibbles with an execution wait after each.
module lcd_4bit_ctrl #(
    parameter int unsigned T_POWERON = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_EXEC    = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_PULSE   = 12,
    parameter int unsigned T_GAP     = 50,
    parameter int unsigned CNT_W     = 32
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       iValid,
    input  logic       iRS,
    input  logic [7:0] iByte,
    output logic       oReady,
    output logic       oInitDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data,
    output logic [3:0] oDbgState
);

    typedef enum logic [3:0] {
        S_PWR_WAIT   = 4'd0,
        S_INIT_SETUP = 4'd1,
        S_INIT_PULSE = 4'd2,
        S_INIT_WAIT  = 4'd3,
        S_SETUP_HI   = 4'd4,
        S_PULSE_HI   = 4'd5,
        S_GAP        = 4'd6,
        S_SETUP_LO   = 4'd7,
        S_PULSE_LO   = 4'd8,
        S_EXEC_WAIT  = 4'd9,
        S_IDLE       = 4'd10
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       init_idx_q;
    logic [1:0]       cfg_idx_q;
    logic [7:0]       byte_q;
    logic             rs_q;
    logic             e_q;
    logic [3:0]       data_q;
    logic             ready_q;
    logic             done_q;

    logic [CNT_W-1:0] wait_len_d;
    logic             cnt_last_d;
    logic             is_clear_d;
    logic [1:0]       cfg_sel_d;
    logic [7:0]       cfg_next_d;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_byte = 8'h28;
            2'd1:    cfg_byte = 8'h06;
            2'd2:    cfg_byte = 8'h0C;
            default: cfg_byte = 8'h01;
        endcase
    endfunction

    // Clear/home commands need the long execution time; everything else uses T_EXEC.
    assign is_clear_d = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

    always_comb begin
        wait_len_d = '0;
        case (state_q)
            S_PWR_WAIT:                           wait_len_d = CNT_W'(T_POWERON);
            S_INIT_SETUP, S_SETUP_HI, S_SETUP_LO: wait_len_d = CNT_W'(T_SETUP);
            S_INIT_PULSE, S_PULSE_HI, S_PULSE_LO: wait_len_d = CNT_W'(T_PULSE);
            S_GAP:                                wait_len_d = CNT_W'(T_GAP);
            S_INIT_WAIT: begin
                case (init_idx_q)
                    2'd0:    wait_len_d = CNT_W'(T_INIT1);
                    2'd1:    wait_len_d = CNT_W'(T_INIT2);
                    default: wait_len_d = CNT_W'(T_EXEC);
                endcase
            end
            S_EXEC_WAIT: wait_len_d = is_clear_d ? CNT_W'(T_CLEAR) : CNT_W'(T_EXEC);
            default:     wait_len_d = '0;
        endcase
    end

    // The counter restarts at 0 on every state entry, so a wait of N ends on count N-1.
    assign cnt_last_d = (cnt_q == wait_len_d - CNT_W'(1));

    // Leaving the init nibbles starts configuration byte 0; later exits load the next entry.
    assign cfg_sel_d  = (state_q == S_INIT_WAIT) ? 2'd0 : cfg_idx_q + 2'd1;
    assign cfg_next_d = cfg_byte(cfg_sel_d);

    // Handshake: a byte transfers on the rising edge where iValid && oReady are both 1;
    // iRS/iByte are captured on that edge, oReady drops the next cycle, and iValid is
    // ignored (not queued) whenever oReady is 0. oReady only ever rises in IDLE.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_PWR_WAIT;
            cnt_q      <= '0;
            init_idx_q <= 2'd0;
            cfg_idx_q  <= 2'd0;
            byte_q     <= 8'h00;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            data_q     <= 4'h0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                S_PWR_WAIT: begin
                    if (cnt_last_d) begin
                        state_q    <= S_INIT_SETUP;
                        cnt_q      <= '0;
                        init_idx_q <= 2'd0;
                        data_q     <= 4'h3;
                        rs_q       <= 1'b0;
                    end
                end
                S_INIT_SETUP: begin
                    if (cnt_last_d) begin
                        state_q <= S_INIT_PULSE;
                        cnt_q   <= '0;
                        e_q     <= 1'b1;
                    end
                end
                S_INIT_PULSE: begin
                    if (cnt_last_d) begin
                        state_q <= S_INIT_WAIT;
                        cnt_q   <= '0;
                        e_q     <= 1'b0;
                    end
                end
                S_INIT_WAIT: begin
                    if (cnt_last_d) begin
                        cnt_q <= '0;
                        if (init_idx_q == 2'd3) begin
                            state_q   <= S_SETUP_HI;
                            cfg_idx_q <= 2'd0;
                            byte_q    <= cfg_next_d;
                            rs_q      <= 1'b0;
                            data_q    <= cfg_next_d[7:4];
                        end else begin
                            state_q    <= S_INIT_SETUP;
                            init_idx_q <= init_idx_q + 2'd1;
                            data_q     <= (init_idx_q == 2'd2) ? 4'h2 : 4'h3;
                        end
                    end
                end
                S_SETUP_HI: begin
                    if (cnt_last_d) begin
                        state_q <= S_PULSE_HI;
                        cnt_q   <= '0;
                        e_q     <= 1'b1;
                    end
                end
                S_PULSE_HI: begin
                    if (cnt_last_d) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                        e_q     <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (cnt_last_d) begin
                        state_q <= S_SETUP_LO;
                        cnt_q   <= '0;
                        data_q  <= byte_q[3:0];
                    end
                end
                S_SETUP_LO: begin
                    if (cnt_last_d) begin
                        state_q <= S_PULSE_LO;
                        cnt_q   <= '0;
                        e_q     <= 1'b1;
                    end
                end
                S_PULSE_LO: begin
                    if (cnt_last_d) begin
                        state_q <= S_EXEC_WAIT;
                        cnt_q   <= '0;
                        e_q     <= 1'b0;
                    end
                end
                S_EXEC_WAIT: begin
                    if (cnt_last_d) begin
                        cnt_q <= '0;
                        if (!done_q && cfg_idx_q != 2'd3) begin
                            state_q   <= S_SETUP_HI;
                            cfg_idx_q <= cfg_idx_q + 2'd1;
                            byte_q    <= cfg_next_d;
                            rs_q      <= 1'b0;
                            data_q    <= cfg_next_d[7:4];
                        end else begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    cnt_q <= '0;
                    if (iValid && ready_q) begin
                        state_q <= S_SETUP_HI;
                        byte_q  <= iByte;
                        rs_q    <= iRS;
                        data_q  <= iByte[7:4];
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_PWR_WAIT;
                    cnt_q   <= '0;
                    e_q     <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign oReady                  = ready_q;
    assign oInitDone               = done_q;
    assign oLCD_Enabled            = e_q;
    assign oLCD_RegisterSelect     = rs_q;
    assign oLCD_Data               = data_q;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oDbgState               = state_q;

endmodule

// File: tb/tb_lcd_4bit_ctrl.sv
// Directed bench for lcd_4bit_ctrl with shortened timing parameters.
module tb_lcd_4bit_ctrl;

  localparam int T_POWERON = 20;
  localparam int T_INIT1   = 10;
  localparam int T_INIT2   = 5;
  localparam int T_EXEC    = 4;
  localparam int T_CLEAR   = 15;
  localparam int T_SETUP   = 2;
  localparam int T_PULSE   = 3;
  localparam int T_GAP     = 2;
  localparam int BUDGET    = 200;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       iValid;
  logic       iRS;
  logic [7:0] iByte;
  logic       oReady;
  logic       oInitDone;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_ReadWrite;
  logic       oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;
  logic [3:0] oDbgState;

  int n_cmp  = 0;
  int n_fail = 0;

  lcd_4bit_ctrl #(
    .T_POWERON(T_POWERON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_EXEC(T_EXEC),
    .T_CLEAR(T_CLEAR), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_GAP(T_GAP), .CNT_W(32)
  ) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .iValid(iValid),
    .iRS(iRS),
    .iByte(iByte),
    .oReady(oReady),
    .oInitDone(oInitDone),
    .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_Data(oLCD_Data),
    .oDbgState(oDbgState)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // per-cycle pin checker
  logic       prev_e = 1'b0;
  logic [3:0] prev_data = 4'h0;
  logic       prev_rs = 1'b0;
  always @(negedge Clock) begin
    chk("rw_const", 32'(oLCD_ReadWrite), 32'd0);
    chk("sf_const", 32'(oLCD_StrataFlashControl), 32'd1);
    chk("ready_before_done", 32'(oReady & ~oInitDone), 32'd0);
    if (oLCD_Enabled && prev_e) begin
      chk("data_stable_e", 32'(oLCD_Data), 32'(prev_data));
      chk("rs_stable_e", 32'(oLCD_RegisterSelect), 32'(prev_rs));
    end
    prev_e    = oLCD_Enabled;
    prev_data = oLCD_Data;
    prev_rs   = oLCD_RegisterSelect;
  end

  // Starts at a sampled negedge; counts low samples before E rises, then E-high samples.
  task automatic nibble(input string tag, input int exp_low, input logic [3:0] exp_data,
                        input logic exp_rs);
    int low;
    int hi;
    low = 0;
    while (!oLCD_Enabled && low < BUDGET) begin
      low++;
      @(negedge Clock);
    end
    chk({tag, "_low"}, 32'(low), 32'(exp_low));
    chk({tag, "_data"}, 32'(oLCD_Data), 32'(exp_data));
    chk({tag, "_rs"}, 32'(oLCD_RegisterSelect), 32'(exp_rs));
    hi = 0;
    while (oLCD_Enabled && hi < BUDGET) begin
      hi++;
      @(negedge Clock);
    end
    chk({tag, "_high"}, 32'(hi), 32'(T_PULSE));
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!oReady && n < BUDGET) begin
      n++;
      @(negedge Clock);
    end
    chk({tag, "_ready_wait"}, 32'(n), 32'(exp_n));
  endtask

  task automatic run_init(input string tag);
    nibble({tag, "_i0"}, T_POWERON + T_SETUP - 1, 4'h3, 1'b0);
    nibble({tag, "_i1"}, T_INIT1 + T_SETUP, 4'h3, 1'b0);
    nibble({tag, "_i2"}, T_INIT2 + T_SETUP, 4'h3, 1'b0);
    nibble({tag, "_i3"}, T_EXEC + T_SETUP, 4'h2, 1'b0);
    nibble({tag, "_c28h"}, T_EXEC + T_SETUP, 4'h2, 1'b0);
    nibble({tag, "_c28l"}, T_GAP + T_SETUP, 4'h8, 1'b0);
    nibble({tag, "_c06h"}, T_EXEC + T_SETUP, 4'h0, 1'b0);
    nibble({tag, "_c06l"}, T_GAP + T_SETUP, 4'h6, 1'b0);
    nibble({tag, "_c0ch"}, T_EXEC + T_SETUP, 4'h0, 1'b0);
    nibble({tag, "_c0cl"}, T_GAP + T_SETUP, 4'hC, 1'b0);
    nibble({tag, "_c01h"}, T_EXEC + T_SETUP, 4'h0, 1'b0);
    nibble({tag, "_c01l"}, T_GAP + T_SETUP, 4'h1, 1'b0);
    wait_ready(tag, T_CLEAR);
    chk({tag, "_done"}, 32'(oInitDone), 32'd1);
  endtask

  // Called at a sampled negedge where oReady=1; byte is accepted on the next posedge.
  task automatic send_byte(input string tag, input logic rs, input logic [7:0] byt,
                           input logic hold, input logic [7:0] junk, input int exp_wait);
    iValid = 1'b1;
    iRS    = rs;
    iByte  = byt;
    @(negedge Clock);
    chk({tag, "_ready_low"}, 32'(oReady), 32'd0);
    if (hold) begin
      iByte = ~byt;
      iRS   = ~rs;
    end else begin
      iValid = 1'b0;
    end
    nibble({tag, "_hi"}, T_SETUP, byt[7:4], rs);
    if (hold) begin
      iByte = junk;
      iRS   = 1'b0;
    end
    nibble({tag, "_lo"}, T_GAP + T_SETUP, byt[3:0], rs);
    wait_ready(tag, exp_wait);
  endtask

  // driver sequence
  initial begin
    int n;
    Reset_n = 1'b1;
    iValid  = 1'b1;
    iRS     = 1'b1;
    iByte   = 8'h55;
    #1 Reset_n = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_e", 32'(oLCD_Enabled), 32'd0);
    chk("rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
    chk("rst_data", 32'(oLCD_Data), 32'd0);
    chk("rst_ready", 32'(oReady), 32'd0);
    chk("rst_done", 32'(oInitDone), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    run_init("init1");

    send_byte("b41", 1'b1, 8'h41, 1'b0, 8'h00, T_EXEC);
    send_byte("b01", 1'b0, 8'h01, 1'b0, 8'h00, T_CLEAR);
    send_byte("b80", 1'b0, 8'h80, 1'b0, 8'h00, T_EXEC);
    send_byte("b03", 1'b0, 8'h03, 1'b0, 8'h00, T_CLEAR);
    send_byte("b04", 1'b0, 8'h04, 1'b0, 8'h00, T_EXEC);
    send_byte("d02", 1'b1, 8'h02, 1'b0, 8'h00, T_EXEC);
    send_byte("hold37", 1'b1, 8'h37, 1'b1, 8'h9A, T_EXEC);
    send_byte("next9a", 1'b0, 8'h9A, 1'b0, 8'h00, T_EXEC);

    // reset asserted in the middle of the lower-nibble pulse
    iValid = 1'b1;
    iRS    = 1'b1;
    iByte  = 8'h5A;
    @(negedge Clock);
    iValid = 1'b0;
    nibble("b5a_hi", T_SETUP, 4'h5, 1'b1);
    n = 0;
    while (!oLCD_Enabled && n < BUDGET) begin
      n++;
      @(negedge Clock);
    end
    chk("b5a_lo_low", 32'(n), 32'(T_GAP + T_SETUP));
    @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_e", 32'(oLCD_Enabled), 32'd0);
    chk("arst_ready", 32'(oReady), 32'd0);
    chk("arst_done", 32'(oInitDone), 32'd0);
    chk("arst_data", 32'(oLCD_Data), 32'd0);
    chk("arst_rs", 32'(oLCD_RegisterSelect), 32'd0);
    chk("arst_state", 32'(oDbgState), 32'd0);
    iValid = 1'b1;
    iByte  = 8'hA5;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    run_init("init2");
    send_byte("b48", 1'b1, 8'h48, 1'b0, 8'h00, T_EXEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
